// File: rtl/uart_core_cfg.sv
// Parametrised full-duplex UART: valid/ready TX, synchronised RX with false-start
// rejection and parity/framing error flags.
module uart_core_cfg #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(STOP_BITS * CPB + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CPB - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    generate
        if (CPB < 4) begin : g_bad_cpb
            $error("uart_core_cfg: CLK_FREQ/BAUD_RATE must be at least 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
            $error("uart_core_cfg: DATA_BITS must be in 5..8");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_core_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    logic [2:0]           tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [2:0]           tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_line;

    assign tx_ready = (tx_state == S_IDLE);
    assign tx_done  = (tx_state == S_STOP) && (tx_cnt == STOP_LAST);
    assign tx       = tx_line;

    // TX: tx_line is registered so the pad never sees decode glitches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        tx_par   <= parity_of(tx_data);
                        tx_line  <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_line  <= tx_shift[0];
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == IDX_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx_line  <= tx_par;
                                tx_state <= S_PARITY;
                            end else begin
                                tx_line  <= 1'b1;
                                tx_state <= S_STOP;
                            end
                        end else begin
                            tx_idx   <= tx_idx + 3'd1;
                            tx_shift <= tx_shift >> 1;
                            tx_line  <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_line  <= 1'b1;
                        tx_state <= S_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (tx_cnt == STOP_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: begin
                    tx_line  <= 1'b1;
                    tx_state <= S_IDLE;
                end
            endcase
        end
    end

    // RX stage p0/p1: two-flop synchroniser, idles high like the line
    logic rx_p0, rx_p1, rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_s = rx_p1;

    logic [2:0]           rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [2:0]           rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par;
    logic                 rx_armed;

    assign rx_busy = (rx_state != S_IDLE);

    // RX FSM: rx_armed blocks re-triggering on a line still low after a frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state      <= S_IDLE;
            rx_cnt        <= '0;
            rx_idx        <= '0;
            rx_shift      <= '0;
            rx_par        <= 1'b0;
            rx_armed      <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rx_s) begin
                        rx_armed <= 1'b1;
                    end else if (rx_armed) begin
                        rx_armed <= 1'b0;
                        rx_cnt   <= '0;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                        if (rx_idx == IDX_LAST) begin
                            rx_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_par   <= rx_s;
                        rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt        <= '0;
                        rx_data       <= rx_shift;
                        rx_parity_err <= (PARITY_EN != 0) && (rx_par != parity_of(rx_shift));
                        rx_frame_err  <= ~rx_s;
                        rx_valid      <= 1'b1;
                        rx_state      <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end
endmodule
